// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, issues in-order word requests over
// req/gnt/rvalid, buffers responses in a small FIFO and discards stale data after redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,

    output logic        if_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o
);

    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [31:0]   pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] fifo_count_q;
    logic [PW-1:0] pcq_wr_q;
    logic [PW-1:0] pcq_rd_q;
    logic [PW-1:0] fifo_wr_q;
    logic [PW-1:0] fifo_rd_q;

    logic [31:0]   pcq_mem    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];

    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          gnt_fire;
    logic          rsp_take;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic [CW-1:0] discard_calc;
    logic [31:0]   redirect_target;
    logic          unused_redirect_lsbs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit is computed from registered counters only, so req never depends on inputs
    assign credit_sum      = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign credit_ok       = credit_sum < DEPTH_C;
    assign gnt_fire        = imem_req_o && imem_gnt_i;
    assign rsp_take        = (state_q == FETCH) && imem_rvalid_i && !redirect_i;
    assign rsp_drop        = (state_q == DRAIN) && imem_rvalid_i && (discard_q != '0);
    assign push            = rsp_take;
    assign pop             = if_valid_o && id_ready_i && !redirect_i;
    assign fifo_full       = (fifo_count_q == DEPTH_C[CW-1:0]);
    assign redirect_target = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Responses still owed by memory at the moment of a redirect
    always_comb begin
        discard_calc = '0;
        unique case (state_q)
            FETCH:   discard_calc = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
            DRAIN:   discard_calc = discard_q - CW'(rsp_drop);
            default: discard_calc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_i && (discard_calc != '0)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!redirect_i && (discard_calc == '0)) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_comb begin
        imem_req_o  = (state_q == FETCH) && credit_ok;
        imem_addr_o = pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_count_q  <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
        end else if (redirect_i) begin
            // Everything in flight becomes a discard; the queues restart empty
            pc_q          <= redirect_target;
            outstanding_q <= '0;
            discard_q     <= discard_calc;
            fifo_count_q  <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
        end else begin
            if (gnt_fire) begin
                pc_q     <= pc_q + 32'd4;
                pcq_wr_q <= ptr_inc(pcq_wr_q);
            end
            if (rsp_take) begin
                pcq_rd_q <= ptr_inc(pcq_rd_q);
            end
            outstanding_q <= outstanding_q + CW'(gnt_fire) - CW'(rsp_take);
            if (state_q == DRAIN) begin
                discard_q <= discard_calc;
            end
            if (push) begin
                fifo_wr_q <= ptr_inc(fifo_wr_q);
            end
            if (pop) begin
                fifo_rd_q <= ptr_inc(fifo_rd_q);
            end
            fifo_count_q <= fifo_count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage arrays need no reset: pointers and counts define what is live
    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            pcq_mem[pcq_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_instr[fifo_wr_q] <= imem_rdata_i;
            fifo_pc[fifo_wr_q]    <= pcq_mem[pcq_rd_q];
        end
    end

    always_comb begin
        if_valid_o    = (fifo_count_q != '0);
        if_instr_o    = if_valid_o ? fifo_instr[fifo_rd_q] : NOP;
        if_pc_o       = if_valid_o ? fifo_pc[fifo_rd_q] : RESET_PC;
        if_pc_plus4_o = if_pc_o + 32'd4;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small memory model answers requests, and a
// scoreboard monitor compares every instruction accepted by ID against expected PCs.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .if_valid_o   (if_valid_o),
        .id_ready_i   (id_ready_i),
        .if_instr_o   (if_instr_o),
        .if_pc_o      (if_pc_o),
        .if_pc_plus4_o(if_pc_plus4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    logic        sb_on = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t pend[$];
    int   mem_cyc   = 0;
    int   wait_cnt  = 0;
    int   gnt_delay = 0;
    int   rsp_lat   = 1;
    int   gnt_count = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        id_ready_i    = 1'b0;
        gnt_count     = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d entries still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic end_test();
        id_ready_i = 1'b0;
        sb_on      = 1'b0;
    endtask

    // Memory model: decides gnt/rvalid at the falling edge, responses in order
    initial begin
        rsp_t r;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                wait_cnt      = 0;
                imem_gnt_i    = 1'b0;
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
            end else begin
                mem_cyc++;
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
                if (pend.size() > 0 && pend[0].due <= mem_cyc) begin
                    r             = pend.pop_front();
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = instr_of(r.addr);
                end
                imem_gnt_i = 1'b0;
                if (imem_req_o) begin
                    if (wait_cnt >= gnt_delay) begin
                        imem_gnt_i = 1'b1;
                        pend.push_back('{addr: imem_addr_o, due: mem_cyc + rsp_lat});
                        gnt_count++;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor: every accepted instruction must match the next expected PC
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && sb_on && if_valid_o && id_ready_i && !redirect_i) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected_pc", if_pc_o, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", if_pc_o, e);
                    check("pop_instr", if_instr_o, instr_of(e));
                    check("pop_pc_plus4", if_pc_plus4_o, e + 32'd4);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        id_ready_i    = 1'b0;

        // Reset values, then the back-to-back stream from RESET_PC
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'h0000_0000);
        check("rst_valid", 32'(if_valid_o), 32'd0);
        check("rst_instr", if_instr_o, 32'h0000_0013);
        check("rst_pc", if_pc_o, 32'h0000_0000);
        check("rst_pc_plus4", if_pc_plus4_o, 32'h0000_0004);
        do_reset();
        id_ready_i = 1'b1;
        sb_on      = 1'b1;
        exp_q      = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
        check("boot_c0_req", 32'(imem_req_o), 32'd0);
        step();
        check("boot_c1_req", 32'(imem_req_o), 32'd1);
        check("boot_c1_addr", imem_addr_o, 32'h0000_0000);
        step();
        check("boot_c2_valid", 32'(if_valid_o), 32'd0);
        step();
        check("boot_c3_valid", 32'(if_valid_o), 32'd1);
        check("boot_c3_pc", if_pc_o, 32'h0000_0000);
        wait_empty("stream");
        end_test();

        // ID stalled: only DEPTH requests may be issued
        do_reset();
        sb_on = 1'b1;
        repeat (12) step();
        check("stall_gnt_count", 32'(gnt_count), 32'd2);
        check("stall_req", 32'(imem_req_o), 32'd0);
        check("stall_valid", 32'(if_valid_o), 32'd1);
        check("stall_head_pc", if_pc_o, 32'h0000_0000);
        check("stall_head_instr", if_instr_o, instr_of(32'h0000_0000));
        exp_q      = '{32'h00, 32'h04, 32'h08, 32'h0C};
        id_ready_i = 1'b1;
        wait_empty("stall_release");
        end_test();

        // Grant held off 3 cycles: request must stay stable
        gnt_delay = 3;
        do_reset();
        id_ready_i = 1'b1;
        sb_on      = 1'b1;
        exp_q      = '{32'h00, 32'h04, 32'h08};
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("gntwait_c%0d_req", c), 32'(imem_req_o), 32'd1);
            check($sformatf("gntwait_c%0d_addr", c), imem_addr_o, 32'h0000_0000);
        end
        step();
        check("gntwait_c5_addr", imem_addr_o, 32'h0000_0004);
        wait_empty("gntwait");
        end_test();
        gnt_delay = 0;

        // Redirect with two requests in flight: both responses are dropped
        rsp_lat = 3;
        do_reset();
        id_ready_i = 1'b1;
        sb_on      = 1'b1;
        repeat (3) step();
        check("drain_c3_gnt_count", 32'(gnt_count), 32'd2);
        check("drain_c3_req", 32'(imem_req_o), 32'd0);
        exp_q         = '{32'h100, 32'h104};
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        step();
        redirect_i = 1'b0;
        check("drain_c4_req", 32'(imem_req_o), 32'd0);
        check("drain_c4_valid", 32'(if_valid_o), 32'd0);
        step();
        check("drain_c5_req", 32'(imem_req_o), 32'd0);
        check("drain_c5_valid", 32'(if_valid_o), 32'd0);
        step();
        check("drain_c6_valid", 32'(if_valid_o), 32'd0);
        check("drain_c6_req", 32'(imem_req_o), 32'd1);
        check("drain_c6_addr", imem_addr_o, 32'h0000_0100);
        wait_empty("drain");
        end_test();
        rsp_lat = 1;

        // Redirect, rvalid and pop in one cycle with one request outstanding
        do_reset();
        id_ready_i = 1'b1;
        sb_on      = 1'b1;
        repeat (3) step();
        check("same_c3_valid", 32'(if_valid_o), 32'd1);
        check("same_c3_req", 32'(imem_req_o), 32'd0);
        exp_q         = '{32'h200, 32'h204, 32'h208};
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        check("same_c4_valid", 32'(if_valid_o), 32'd0);
        check("same_c4_req", 32'(imem_req_o), 32'd1);
        check("same_c4_addr", imem_addr_o, 32'h0000_0200);
        wait_empty("same_cycle");
        end_test();

        // Redirect during BOOT to a misaligned address at the top of memory
        do_reset();
        id_ready_i    = 1'b1;
        sb_on         = 1'b1;
        exp_q         = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        step();
        redirect_i = 1'b0;
        check("wrap_c1_req", 32'(imem_req_o), 32'd1);
        check("wrap_c1_addr", imem_addr_o, 32'hFFFF_FFFC);
        step();
        check("wrap_c2_addr", imem_addr_o, 32'h0000_0000);
        wait_empty("wrap");
        end_test();

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch (IF) stage of the RV32 pipeline; sits directly upstream of the ID-stage control unit/decoder.
- Owns the PC register and issues in-order word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to ID with valid/ready.
- Handles redirects from the EX stage (branch/JAL/JALR) by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction FIFO entries; also the maximum of outstanding requests plus buffered entries (2..8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  word-aligned fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid; responses arrive in order, at least 1 cycle after gnt.
- imem_rdata_i  in  32  instruction word.
- redirect_i  in  1  pipeline redirect from EX.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and forced to 0.
- if_valid_o  out  1  FIFO head holds a valid instruction.
- id_ready_i  in  1  ID accepts the head this cycle.
- if_instr_o  out  32  head instruction.
- if_pc_o  out  32  PC of the head instruction.
- if_pc_plus4_o  out  32  if_pc_o + 4, mod 2^32.

Behaviour:
- Reset (async assert, sync release):
  - imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0.
  - if_instr_o=32'h0000_0013 (NOP); if_pc_o=RESET_PC; if_pc_plus4_o=RESET_PC+4.
  - FIFO empty, outstanding=0, discard=0, state=BOOT.
- State machine:
  - BOOT: no request. Next cycle goes to FETCH.
  - FETCH: normal issue and accept.
  - DRAIN: no new requests. Each rvalid is dropped and decrements discard. When discard reaches 0, go to FETCH.
- Issue rule (FETCH only):
  - Start a new request when outstanding + fifo_count < DEPTH, using registered values.
  - Once asserted, imem_req_o and imem_addr_o hold stable until imem_gnt_i, unless redirect_i arrives.
  - On req&&gnt: pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0) and outstanding++.
- Response:
  - In FETCH, rvalid pushes {rdata, pc of that request} into the FIFO and decrements outstanding.
  - Request PCs are tracked in a DEPTH-entry in-order PC queue.
  - Minimum latency: gnt at cycle t, rvalid at t+1, if_valid_o at t+2. There is no bypass.
  - The credit rule guarantees the FIFO never overflows. A push when full is an assertion failure.
- Output:
  - Head registers drive if_instr_o, if_pc_o and if_pc_plus4_o.
  - Pop when if_valid_o && id_ready_i.
  - Push and pop in the same cycle are both performed.
- Redirect (highest priority):
  - pc <= {redirect_pc_i[31:2],2'b00}; FIFO cleared; pop ignored; if_valid_o=0 next cycle.
  - An ungranted pending request is withdrawn: imem_req_o=0 next cycle. The memory treats it as not taken.
  - Compute discard = outstanding + (req&&gnt this cycle) − (rvalid this cycle).
  - If discard > 0, go to DRAIN; otherwise go to FETCH. A request to the new PC may start the next cycle.
- Redirect during DRAIN: discard is updated by the same formula and the state stays DRAIN. The target is replaced with the newest redirect.
- Redirect in BOOT: it overrides RESET_PC.
- Reset mid-operation: all state is cleared immediately. Responses to pre-reset requests are the memory's responsibility and do not occur.

Test Plan:
- Reset release with gnt tied 1 and rvalid 1 cycle later -> first req addr 0x0 in cycle 1. if_valid_o rises in cycle 3 with if_pc_o=0x0. The stream is 0x0, 0x4, 0x8…, one instruction per cycle.
- id_ready_i=0 for 10 cycles, DEPTH=2 -> exactly 2 requests issued, then imem_req_o stays 0. FIFO holds PCs 0x0 and 0x4. Releasing ready delivers them in order with no loss or duplicate.
- gnt delayed 3 cycles -> req/addr held stable across all wait cycles. pc advances only on the gnt cycle.
- Redirect to 0x100 with 2 outstanding -> DRAIN. The two stale rvalids are dropped and if_valid_o stays 0. The next req addr is 0x100, and the first delivered if_pc_o is 0x100.
- Redirect, rvalid and pop all in the same cycle with 1 outstanding -> discard=0, FIFO empty, state FETCH. The next req is to the target. The stale rdata is never presented.
- Redirect to 0xFFFF_FFFE -> fetch at 0xFFFF_FFFC, then 0x0. if_pc_plus4_o=0x0 for the 0xFFFF_FFFC entry.
